// File: rtl/operand_fetch_pkg.sv
// Shared widths and types for the operand-fetch stage and its forwarding mux.
// The writeback-port struct lets the four snooped write ports travel as one array.
package operand_fetch_pkg;

  localparam int DEF_OPRAND_WIDTH  = 32;
  localparam int DEF_ARRAY_ENTRY   = 32;
  localparam int DEF_REGNAME_WIDTH = 5;
  localparam int DEF_PAYLOAD_WIDTH = 16;
  localparam int NUM_WB            = 4;

  // Array order is ascending priority: 11, 12, 21, 22.
  typedef struct packed {
    logic                         en;
    logic [DEF_REGNAME_WIDTH-1:0] addr;
    logic [DEF_OPRAND_WIDTH-1:0]  data;
  } wb_port_t;

endpackage

// File: rtl/operand_fetch_wb_forward.sv
// Combinational 4-port writeback match for one source register.
// Later array entries override earlier ones, so port 22 wins over 21 over 12 over 11.
module wb_forward
  import operand_fetch_pkg::*;
(
  input  wb_port_t [NUM_WB-1:0]         wb,
  input  logic [DEF_REGNAME_WIDTH-1:0]  addr,
  output logic                          hit,
  output logic [DEF_OPRAND_WIDTH-1:0]   data
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb[i].en && (wb[i].addr == addr)) begin
        hit  = 1'b1;
        data = wb[i].data;
      end
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: D holds the issued instruction until its sources are free,
// O is the registered output to execute. Owns the busy-bit scoreboard.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int OPRAND_WIDTH  = DEF_OPRAND_WIDTH,
  parameter int ARRAY_ENTRY   = DEF_ARRAY_ENTRY,
  parameter int REGNAME_WIDTH = DEF_REGNAME_WIDTH,
  parameter int PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [REGNAME_WIDTH-1:0] in_rs1_i,
  input  logic [REGNAME_WIDTH-1:0] in_rs2_i,
  input  logic                     in_use_rs1_i,
  input  logic                     in_use_rs2_i,
  input  logic [REGNAME_WIDTH-1:0] in_rd_i,
  input  logic                     in_rd_we_i,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload_i,
  output logic [REGNAME_WIDTH-1:0] read1_addr_o,
  output logic [REGNAME_WIDTH-1:0] read2_addr_o,
  output logic                     read1_en_o,
  output logic                     read2_en_o,
  input  logic [OPRAND_WIDTH-1:0]  read1_data_i,
  input  logic [OPRAND_WIDTH-1:0]  read2_data_i,
  input  logic                     read1_ready_i,
  input  logic                     read2_ready_i,
  input  logic                     write11_en_i,
  input  logic                     write12_en_i,
  input  logic                     write21_en_i,
  input  logic                     write22_en_i,
  input  logic [REGNAME_WIDTH-1:0] write11_addr_i,
  input  logic [REGNAME_WIDTH-1:0] write12_addr_i,
  input  logic [REGNAME_WIDTH-1:0] write21_addr_i,
  input  logic [REGNAME_WIDTH-1:0] write22_addr_i,
  input  logic [OPRAND_WIDTH-1:0]  write11_data_i,
  input  logic [OPRAND_WIDTH-1:0]  write12_data_i,
  input  logic [OPRAND_WIDTH-1:0]  write21_data_i,
  input  logic [OPRAND_WIDTH-1:0]  write22_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [OPRAND_WIDTH-1:0]  out_op1_o,
  output logic [OPRAND_WIDTH-1:0]  out_op2_o,
  output logic [REGNAME_WIDTH-1:0] out_rd_o,
  output logic                     out_rd_we_o,
  output logic [PAYLOAD_WIDTH-1:0] out_payload_o
);

  typedef struct packed {
    logic                     valid;
    logic [REGNAME_WIDTH-1:0] rs1;
    logic [REGNAME_WIDTH-1:0] rs2;
    logic                     use_rs1;
    logic                     use_rs2;
    logic [REGNAME_WIDTH-1:0] rd;
    logic                     rd_we;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } d_slot_t;

  typedef struct packed {
    logic                     valid;
    logic [OPRAND_WIDTH-1:0]  op1;
    logic [OPRAND_WIDTH-1:0]  op2;
    logic [REGNAME_WIDTH-1:0] rd;
    logic                     rd_we;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } o_slot_t;

  d_slot_t                 d_q;
  o_slot_t                 o_q;
  logic [ARRAY_ENTRY-1:0]  busy_q;
  logic [ARRAY_ENTRY-1:0]  busy_next;
  wb_port_t [NUM_WB-1:0]   wb;

  logic                    fwd_hit1, fwd_hit2;
  logic [OPRAND_WIDTH-1:0] fwd_data1, fwd_data2;
  logic [OPRAND_WIDTH-1:0] op1_sel, op2_sel;
  logic                    src1_ok, src2_ok, d_adv, accept;

  assign wb[0] = '{en: write11_en_i, addr: write11_addr_i, data: write11_data_i};
  assign wb[1] = '{en: write12_en_i, addr: write12_addr_i, data: write12_data_i};
  assign wb[2] = '{en: write21_en_i, addr: write21_addr_i, data: write21_data_i};
  assign wb[3] = '{en: write22_en_i, addr: write22_addr_i, data: write22_data_i};

  wb_forward u_fwd1 (.wb(wb), .addr(d_q.rs1), .hit(fwd_hit1), .data(fwd_data1));
  wb_forward u_fwd2 (.wb(wb), .addr(d_q.rs2), .hit(fwd_hit2), .data(fwd_data2));

  assign read1_addr_o = d_q.rs1;
  assign read2_addr_o = d_q.rs2;
  assign read1_en_o   = d_q.valid && d_q.use_rs1;
  assign read2_en_o   = d_q.valid && d_q.use_rs2;

  // A snooped write makes a busy source usable in the same cycle it lands.
  assign src1_ok = !d_q.use_rs1 || fwd_hit1 || (!busy_q[d_q.rs1] && read1_ready_i);
  assign src2_ok = !d_q.use_rs2 || fwd_hit2 || (!busy_q[d_q.rs2] && read2_ready_i);

  assign op1_sel = !d_q.use_rs1 ? '0 : (fwd_hit1 ? fwd_data1 : read1_data_i);
  assign op2_sel = !d_q.use_rs2 ? '0 : (fwd_hit2 ? fwd_data2 : read2_data_i);

  assign d_adv      = d_q.valid && src1_ok && src2_ok && (!o_q.valid || out_ready_i);
  assign in_ready_o = !d_q.valid || d_adv;
  assign accept     = in_valid_i && in_ready_o;

  // Set is applied after the clears so a same-cycle write to the new rd leaves it busy.
  always_comb begin
    busy_next = busy_q;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb[i].en) busy_next[wb[i].addr] = 1'b0;
    end
    if (d_adv && d_q.rd_we) busy_next[d_q.rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= '0;
      o_q    <= '0;
      busy_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
      busy_q <= busy_next;

      if (accept) begin
        d_q <= '{valid: 1'b1, rs1: in_rs1_i, rs2: in_rs2_i, use_rs1: in_use_rs1_i,
                 use_rs2: in_use_rs2_i, rd: in_rd_i, rd_we: in_rd_we_i, payload: in_payload_i};
      end else if (d_adv) begin
        d_q.valid <= 1'b0;
      end

      if (d_adv) begin
        o_q <= '{valid: 1'b1, op1: op1_sel, op2: op2_sel, rd: d_q.rd,
                 rd_we: d_q.rd_we, payload: d_q.payload};
      end else if (out_ready_i) begin
        o_q.valid <= 1'b0;
      end
    end
  end

  assign out_valid_o   = o_q.valid;
  assign out_op1_o     = o_q.op1;
  assign out_op2_o     = o_q.op2;
  assign out_rd_o      = o_q.rd;
  assign out_rd_we_o   = o_q.rd_we;
  assign out_payload_o = o_q.payload;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a vector table for the steady stream, then
// hand-written sequences for stalls, forwarding priority, backpressure and reset.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_rd_we;
  logic [15:0] in_payload;
  logic [4:0]  read1_addr, read2_addr;
  logic        read1_en, read2_en;
  logic [31:0] read1_data, read2_data;
  logic        read1_ready, read2_ready;
  logic        w_en   [4];
  logic [4:0]  w_addr [4];
  logic [31:0] w_data [4];
  logic        out_valid, out_ready, out_rd_we;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic [15:0] out_payload;
  logic [31:0] regs [32];

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        use1, use2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [15:0] payload;
    logic [31:0] exp1, exp2;
  } vec_t;

  vec_t vecs [6];

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .in_use_rs1_i(in_use_rs1), .in_use_rs2_i(in_use_rs2),
    .in_rd_i(in_rd), .in_rd_we_i(in_rd_we), .in_payload_i(in_payload),
    .read1_addr_o(read1_addr), .read2_addr_o(read2_addr),
    .read1_en_o(read1_en), .read2_en_o(read2_en),
    .read1_data_i(read1_data), .read2_data_i(read2_data),
    .read1_ready_i(read1_ready), .read2_ready_i(read2_ready),
    .write11_en_i(w_en[0]), .write12_en_i(w_en[1]),
    .write21_en_i(w_en[2]), .write22_en_i(w_en[3]),
    .write11_addr_i(w_addr[0]), .write12_addr_i(w_addr[1]),
    .write21_addr_i(w_addr[2]), .write22_addr_i(w_addr[3]),
    .write11_data_i(w_data[0]), .write12_data_i(w_data[1]),
    .write21_data_i(w_data[2]), .write22_data_i(w_data[3]),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_op1_o(out_op1), .out_op2_o(out_op2),
    .out_rd_o(out_rd), .out_rd_we_o(out_rd_we), .out_payload_o(out_payload)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int k);
    if (k == 3) return 32'h11;
    if (k == 4) return 32'h22;
    return 32'hC0DE_0000 + k;
  endfunction

  // Register-file model: ascending port order so port 22 lands last.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 32; k++) regs[k] <= init_val(k);
    end else begin
      for (int i = 0; i < 4; i++) if (w_en[i]) regs[w_addr[i]] <= w_data[i];
    end
  end

  assign read1_data = regs[read1_addr];
  assign read2_data = regs[read2_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic we,
                       input logic [15:0] pl);
    in_valid   = 1'b1;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_use_rs1 = u1;
    in_use_rs2 = u2;
    in_rd      = rd;
    in_rd_we   = we;
    in_payload = pl;
  endtask

  task automatic wr(input int idx, input logic [4:0] addr, input logic [31:0] data);
    w_en[idx]   = 1'b1;
    w_addr[idx] = addr;
    w_data[idx] = data;
  endtask

  task automatic clear_wr();
    for (int i = 0; i < 4; i++) begin
      w_en[i]   = 1'b0;
      w_addr[i] = '0;
      w_data[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    preload = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    clear_wr();
    tick();
    tick();
    rst = 1'b0;
    preload = 1'b0;
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1; out_ready = 1'b1;
    read1_ready = 1'b1; read2_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    clear_wr();

    vecs[0] = '{rs1: 3,  rs2: 4,  use1: 1, use2: 1, rd: 10, rd_we: 0, payload: 16'h1111,
                exp1: 32'h11,        exp2: 32'h22};
    vecs[1] = '{rs1: 1,  rs2: 2,  use1: 1, use2: 0, rd: 11, rd_we: 0, payload: 16'h2222,
                exp1: 32'hC0DE0001, exp2: 32'h0};
    vecs[2] = '{rs1: 6,  rs2: 6,  use1: 0, use2: 1, rd: 12, rd_we: 0, payload: 16'h3333,
                exp1: 32'h0,         exp2: 32'hC0DE0006};
    vecs[3] = '{rs1: 0,  rs2: 31, use1: 1, use2: 1, rd: 20, rd_we: 1, payload: 16'h4444,
                exp1: 32'hC0DE0000, exp2: 32'hC0DE001F};
    vecs[4] = '{rs1: 15, rs2: 16, use1: 1, use2: 1, rd: 21, rd_we: 1, payload: 16'h5555,
                exp1: 32'hC0DE000F, exp2: 32'hC0DE0010};
    vecs[5] = '{rs1: 3,  rs2: 3,  use1: 1, use2: 1, rd: 22, rd_we: 0, payload: 16'h6666,
                exp1: 32'h11,        exp2: 32'h11};

    // Reset state.
    do_reset();
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_read_en", {read1_en, read2_en}, 0);
    check("reset_out_fields", {out_op1, out_op2, out_rd, out_rd_we, out_payload}, 0);

    // Independent stream, one issue per cycle, 2-cycle latency.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].use1, vecs[i].use2,
            vecs[i].rd, vecs[i].rd_we, vecs[i].payload);
      #1;
      check($sformatf("stream_in_ready_%0d", i), in_ready, 1);
      tick();
      if (i > 0) begin
        check($sformatf("stream_valid_%0d", i - 1), out_valid, 1);
        check($sformatf("stream_ops_%0d", i - 1), {out_op1, out_op2},
              {vecs[i-1].exp1, vecs[i-1].exp2});
        check($sformatf("stream_meta_%0d", i - 1), {out_rd, out_rd_we, out_payload},
              {vecs[i-1].rd, vecs[i-1].rd_we, vecs[i-1].payload});
      end
    end
    in_valid = 1'b0;
    tick();
    check("stream_last_ops", {out_valid, out_op1, out_op2}, {1'b1, vecs[5].exp1, vecs[5].exp2});
    tick();
    check("stream_drained", out_valid, 0);

    // RAW stall: B reads r7 written by A; released by write21.
    do_reset();
    drive(1, 0, 1, 0, 7, 1, 16'h000A);
    tick();
    drive(7, 0, 1, 0, 8, 0, 16'h000B);
    #1;
    check("raw_accept_b", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("raw_a_out", {out_valid, out_op1, out_payload}, {1'b1, 32'hC0DE0001, 16'h000A});
    for (int c = 0; c < 5; c++) begin
      check($sformatf("raw_stall_ready_%0d", c), in_ready, 0);
      check($sformatf("raw_stall_read_%0d", c), {read1_en, read1_addr}, {1'b1, 5'd7});
      tick();
      check($sformatf("raw_stall_valid_%0d", c), out_valid, 0);
    end
    wr(2, 7, 32'hABCD);
    #1;
    check("raw_release_ready", in_ready, 1);
    tick();
    clear_wr();
    check("raw_b_out", {out_valid, out_op1, out_payload}, {1'b1, 32'hABCD, 16'h000B});
    check("raw_busy7_clear", dut.busy_q[7], 0);

    // Write-port priority: 11 and 22 hit r9 together.
    do_reset();
    drive(0, 0, 0, 0, 9, 1, 16'h000C);
    tick();
    drive(9, 9, 1, 1, 12, 0, 16'h000D);
    #1;
    check("prio_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    check("prio_stalled", in_ready, 0);
    wr(0, 9, 32'h1);
    wr(3, 9, 32'h2);
    #1;
    check("prio_release", in_ready, 1);
    tick();
    clear_wr();
    check("prio_ops", {out_valid, out_op1, out_op2}, {1'b1, 32'h2, 32'h2});
    check("prio_busy9_clear", dut.busy_q[9], 0);

    // Backpressure: O and D hold, then drain in order.
    do_reset();
    out_ready = 1'b0;
    drive(3, 0, 1, 0, 1, 0, 16'h0010);
    tick();
    drive(4, 0, 1, 0, 2, 0, 16'h0011);
    #1;
    check("bp_accept_i1", in_ready, 1);
    tick();
    drive(1, 0, 1, 0, 3, 0, 16'h0012);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("bp_hold_ready_%0d", c), in_ready, 0);
      check($sformatf("bp_hold_out_%0d", c), {out_valid, out_op1, out_payload},
            {1'b1, 32'h11, 16'h0010});
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_drain_1", {out_valid, out_op1, out_payload}, {1'b1, 32'h22, 16'h0011});
    tick();
    check("bp_drain_2", {out_valid, out_op1, out_payload}, {1'b1, 32'hC0DE0001, 16'h0012});
    tick();
    check("bp_drain_done", out_valid, 0);

    // Self-dependency with same-cycle write to rd: proceeds, set wins.
    do_reset();
    drive(5, 0, 1, 0, 5, 1, 16'h0005);
    tick();
    in_valid = 1'b0;
    wr(1, 5, 32'h55);
    #1;
    check("self_proceeds", in_ready, 1);
    tick();
    clear_wr();
    check("self_out", {out_valid, out_op1, out_rd, out_rd_we}, {1'b1, 32'h55, 5'd5, 1'b1});
    check("self_busy5_set", dut.busy_q[5], 1);
    drive(5, 0, 1, 0, 6, 0, 16'h0006);
    tick();
    in_valid = 1'b0;
    tick();
    check("self_follower_stalls", {in_ready, out_valid}, 0);

    // Reset mid-stream with D, O valid and busy = 0xFF.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 0, 0, 5'(k), (k < 8), 16'(k));
      tick();
    end
    in_valid = 1'b0;
    check("mid_busy_ff", dut.busy_q, 32'hFF);
    check("mid_slots_valid", {out_valid, dut.d_q.valid}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset_valid", out_valid, 0);
    check("mid_reset_busy", dut.busy_q, 0);
    check("mid_reset_ready", {in_ready, read1_en}, 2'b10);
    check("mid_reset_fields", {out_op1, out_rd, out_rd_we, out_payload}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
